// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key-event receiver.
// Holds the prefix codes, the frame FSM encoding and the queued event layout.
// No timing or flow control lives here.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DPS  = 2'd1,
    ST_LOAD = 2'd2
  } frame_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  // Frame as shifted in: bit0 start, bits 8:1 data (LSB first), bit9 parity, bit10 stop.
  // Good frame: start low, stop high, odd parity over data plus parity bit.
  function automatic logic frame_ok(input logic [10:0] frm);
    return (frm[0] == 1'b0) && (frm[10] == 1'b1) && ((^frm[9:1]) == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: glitch filter, 11-bit frame capture, start/parity/stop check, gap timeout.
// Latency: stop-bit falling edge in cycle N -> byte_tick (or frame_err) in cycle N+1.
// No backpressure: byte_tick is a one-cycle strobe the consumer must take.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic       byte_tick,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int GW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYC - 1);

  logic [FILTER_LEN-1:0] filt;
  logic                  f_ps2c;
  logic                  f_ps2c_next;
  logic                  fall;

  frame_state_t  state, state_next;
  logic [10:0]   shreg, shreg_next;
  logic [3:0]    n, n_next;
  logic [GW-1:0] gap, gap_next;

  // The filtered clock only changes once the whole window agrees.
  assign f_ps2c_next = (&filt) ? 1'b1 : ((|filt) ? f_ps2c : 1'b0);
  assign fall        = f_ps2c & ~f_ps2c_next;
  assign rx_byte     = shreg[8:1];

  // Glitch filter shift register and filtered clock level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt   <= '0;
      f_ps2c <= 1'b0;
    end else begin
      filt   <= {ps2c, filt[FILTER_LEN-1:1]};
      f_ps2c <= f_ps2c_next;
    end
  end

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      shreg <= '0;
      n     <= '0;
      gap   <= '0;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      n     <= n_next;
      gap   <= gap_next;
    end
  end

  // Next-state, bit shifting, gap timeout and frame verdict.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    n_next     = n;
    gap_next   = gap;
    byte_tick  = 1'b0;
    frame_err  = 1'b0;
    case (state)
      ST_IDLE: begin
        // rx_en only gates the start; an accepted frame always runs to completion.
        if (fall && rx_en) begin
          state_next = ST_DPS;
          shreg_next = {ps2d, shreg[10:1]};
          n_next     = 4'd9;
          gap_next   = '0;
        end
      end
      ST_DPS: begin
        if (fall) begin
          shreg_next = {ps2d, shreg[10:1]};
          gap_next   = '0;
          if (n == 4'd0) begin
            state_next = ST_LOAD;
          end else begin
            n_next = n - 4'd1;
          end
        end else if (gap == GAP_LAST) begin
          // Keyboard stalled mid-frame: drop the partial frame.
          state_next = ST_IDLE;
          frame_err  = 1'b1;
        end else begin
          gap_next = gap + GW'(1);
        end
      end
      ST_LOAD: begin
        state_next = ST_IDLE;
        if (frame_ok(shreg)) begin
          byte_tick = 1'b1;
        end else begin
          frame_err = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: frames -> E0/F0 prefix decoding -> key-event FIFO.
// Latency: stop-bit fall in cycle N -> evt_valid in N+2 when the FIFO was empty.
// Backpressure: valid/ready pop; a push into a full FIFO with no pop is dropped and flagged.
module ps2_key_event_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 100000,
  parameter int EVENT_MODE  = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ps2c,
  input  logic                            ps2d,
  input  logic                            rx_en,
  output logic                            evt_valid,
  input  logic                            evt_ready,
  output logic [7:0]                      evt_code,
  output logic                            evt_ext,
  output logic                            evt_break,
  output logic                            frame_err,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic          byte_tick;
  logic [7:0]    rx_byte;
  logic          ext_q;
  logic          brk_q;
  evt_t          mem [FIFO_DEPTH];
  evt_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          is_code;
  logic          push_req;
  logic          full;
  logic          pop;
  logic          do_push;

  ps2_frame_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .rx_en     (rx_en),
    .byte_tick (byte_tick),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  assign is_code  = byte_tick && (rx_byte != PS2_EXT) && (rx_byte != PS2_BRK);
  // Legacy mode only reports releases; press codes are swallowed.
  assign push_req = is_code && (brk_q || (EVENT_MODE != 0));
  assign full     = (count == FULL_CNT);
  assign pop      = evt_valid && evt_ready;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign do_push  = push_req && (!full || pop);

  assign head       = mem[rd_ptr];
  assign evt_valid  = (count != '0);
  assign evt_code   = evt_valid ? head.code : 8'h00;
  assign evt_ext    = evt_valid ? head.ext  : 1'b0;
  assign evt_break  = evt_valid ? head.brk  : 1'b0;
  assign fifo_count = count;

  // Prefix flags: set by E0/F0, consumed by the next code, wiped by a bad frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (frame_err) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (byte_tick) begin
      if (rx_byte == PS2_EXT) begin
        ext_q <= 1'b1;
      end else if (rx_byte == PS2_BRK) begin
        brk_q <= 1'b1;
      end else begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end

  // Event storage; stale contents are masked at the outputs while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= {ext_q, brk_q, rx_byte};
    end
  end

  // Pointers, occupancy and the registered overflow pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow <= push_req && full && !pop;
    end
  end

endmodule
